// File: rtl/arbiter_req_queues.sv
// Per-requester request FIFOs feeding a round-robin arbiter.
// Each queue raises req_vec while non-empty. The arbiter's grant pops the head of the
// granted queue, and that entry is presented on a registered dequeue port one cycle later.
module arbiter_req_queues #(
    parameter int REQUESTER_COUNT     = 4,
    parameter int LOG_REQUESTER_COUNT = 2,
    parameter int QUEUE_DEPTH         = 4,
    parameter int LOG_QUEUE_DEPTH     = 2,
    parameter int DATA_WIDTH          = 32
) (
    input  logic                                             CLK,
    input  logic                                             RST,
    input  logic [REQUESTER_COUNT-1:0]                       enq_valid_vec,
    input  logic [REQUESTER_COUNT-1:0][DATA_WIDTH-1:0]       enq_data_by_req,
    output logic [REQUESTER_COUNT-1:0]                       enq_ready_vec,
    output logic [REQUESTER_COUNT-1:0]                       req_vec,
    input  logic [REQUESTER_COUNT-1:0]                       ack_one_hot,
    input  logic [LOG_REQUESTER_COUNT-1:0]                   ack_index,
    output logic                                             deq_valid,
    output logic [DATA_WIDTH-1:0]                            deq_data,
    output logic [LOG_REQUESTER_COUNT-1:0]                   deq_req_index
);

    localparam logic [LOG_QUEUE_DEPTH:0]   FULL_COUNT = (LOG_QUEUE_DEPTH+1)'(QUEUE_DEPTH);
    localparam logic [LOG_QUEUE_DEPTH:0]   COUNT_ONE  = (LOG_QUEUE_DEPTH+1)'(1);
    localparam logic [LOG_QUEUE_DEPTH-1:0] PTR_ONE    = LOG_QUEUE_DEPTH'(1);

    logic [DATA_WIDTH-1:0]                             queue_mem [REQUESTER_COUNT][QUEUE_DEPTH];
    logic [REQUESTER_COUNT-1:0][LOG_QUEUE_DEPTH-1:0]   head_reg;
    logic [REQUESTER_COUNT-1:0][LOG_QUEUE_DEPTH-1:0]   tail_reg;
    logic [REQUESTER_COUNT-1:0][LOG_QUEUE_DEPTH:0]     count_reg;
    logic [REQUESTER_COUNT-1:0]                        push_vec;
    logic [REQUESTER_COUNT-1:0]                        pop_vec;

    // Status flags come from registered counts only. This keeps the full and non-empty
    // decisions free of combinational paths from the enqueue or grant inputs.
    // A grant pops a queue only when the one-hot bit and the index agree and the queue
    // holds data. Any other grant pattern is treated as no grant.
    generate
        for (genvar gi = 0; gi < REQUESTER_COUNT; gi++) begin : g_queue_flags
            assign enq_ready_vec[gi] = (count_reg[gi] != FULL_COUNT);
            assign req_vec[gi]       = (count_reg[gi] != '0);
            assign push_vec[gi]      = enq_valid_vec[gi] & enq_ready_vec[gi];
            assign pop_vec[gi]       = ack_one_hot[gi] & req_vec[gi]
                                       & (ack_index == LOG_REQUESTER_COUNT'(gi));
        end
    endgenerate

    // Pointer and occupancy bookkeeping for every queue.
    // A push and a pop in the same cycle move both pointers and leave the count unchanged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < REQUESTER_COUNT; i++) begin
                if (push_vec[i]) tail_reg[i] <= tail_reg[i] + PTR_ONE;
                if (pop_vec[i])  head_reg[i] <= head_reg[i] + PTR_ONE;
                case ({push_vec[i], pop_vec[i]})
                    2'b10:   count_reg[i] <= count_reg[i] + COUNT_ONE;
                    2'b01:   count_reg[i] <= count_reg[i] - COUNT_ONE;
                    default: count_reg[i] <= count_reg[i];
                endcase
            end
        end
    end

    // Payload storage. It has no reset: entries are only meaningful between tail and head.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (push_vec[i]) queue_mem[i][tail_reg[i]] <= enq_data_by_req[i];
        end
    end

    // Registered dequeue port. It captures the popped head and its source.
    // When nothing is popped, the last payload and index are held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deq_valid     <= 1'b0;
            deq_data      <= '0;
            deq_req_index <= '0;
        end else begin
            deq_valid <= |pop_vec;
            if (|pop_vec) begin
                deq_data      <= queue_mem[ack_index][head_reg[ack_index]];
                deq_req_index <= ack_index;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_req_queues.sv
// Bench for arbiter_req_queues.
// A queue-based behavioural model predicts every output after each clock.
// Directed scenarios pin the model with literal expectations, followed by a randomized run.
module tb_arbiter_req_queues;

    logic              CLK;
    logic              RST;
    logic [3:0]        enq_valid_vec;
    logic [3:0][31:0]  enq_data_by_req;
    logic [3:0]        enq_ready_vec;
    logic [3:0]        req_vec;
    logic [3:0]        ack_one_hot;
    logic [1:0]        ack_index;
    logic              deq_valid;
    logic [31:0]       deq_data;
    logic [1:0]        deq_req_index;

    arbiter_req_queues #(
        .REQUESTER_COUNT(4), .LOG_REQUESTER_COUNT(2),
        .QUEUE_DEPTH(4), .LOG_QUEUE_DEPTH(2), .DATA_WIDTH(32)
    ) dut (
        .CLK(CLK), .RST(RST),
        .enq_valid_vec(enq_valid_vec), .enq_data_by_req(enq_data_by_req),
        .enq_ready_vec(enq_ready_vec), .req_vec(req_vec),
        .ack_one_hot(ack_one_hot), .ack_index(ack_index),
        .deq_valid(deq_valid), .deq_data(deq_data), .deq_req_index(deq_req_index)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: one SystemVerilog queue per requester, plus the expected output register.
    logic [31:0] mq [4][$];
    logic        exp_dv;
    logic [31:0] exp_dd;
    logic [1:0]  exp_idx;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Compares every DUT output against the model.
    task automatic check_all();
        logic [3:0] m_req;
        logic [3:0] m_rdy;
        for (int i = 0; i < 4; i++) begin
            m_req[i] = (mq[i].size() != 0);
            m_rdy[i] = (mq[i].size() != 4);
        end
        cmp("req_vec", {28'd0, req_vec}, {28'd0, m_req});
        cmp("enq_ready_vec", {28'd0, enq_ready_vec}, {28'd0, m_rdy});
        cmp("deq_valid", {31'd0, deq_valid}, {31'd0, exp_dv});
        cmp("deq_data", deq_data, exp_dd);
        cmp("deq_req_index", {30'd0, deq_req_index}, {30'd0, exp_idx});
    endtask

    // Drives one cycle of inputs, advances the model, clocks the DUT, and then checks it.
    task automatic step(input logic [3:0] ev, input logic [3:0][31:0] d,
                        input logic [3:0] ah, input logic [1:0] ai);
        logic [3:0] push;
        logic       pop;
        enq_valid_vec   = ev;
        enq_data_by_req = d;
        ack_one_hot     = ah;
        ack_index       = ai;
        for (int i = 0; i < 4; i++) push[i] = ev[i] && (mq[i].size() < 4);
        pop = ah[ai] && (mq[ai].size() != 0);
        exp_dv = pop;
        if (pop) begin
            exp_dd  = mq[ai].pop_front();
            exp_idx = ai;
            $display("deq q%0d data %h", ai, exp_dd);
        end
        for (int i = 0; i < 4; i++) if (push[i]) mq[i].push_back(d[i]);
        @(posedge CLK);
        #2;
        enq_valid_vec = '0;
        ack_one_hot   = '0;
        check_all();
    endtask

    function automatic logic [3:0][31:0] lane(input int q, input logic [31:0] v);
        logic [3:0][31:0] r;
        r    = '0;
        r[q] = v;
        return r;
    endfunction

    // Asserts reset between edges and expects every output at its reset value.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) mq[i].delete();
        exp_dv = 1'b0; exp_dd = '0; exp_idx = '0;
        cmp("rst_req_vec", {28'd0, req_vec}, 32'h0);
        cmp("rst_enq_ready", {28'd0, enq_ready_vec}, 32'hF);
        cmp("rst_deq_valid", {31'd0, deq_valid}, 32'h0);
        cmp("rst_deq_data", deq_data, 32'h0);
        cmp("rst_deq_idx", {30'd0, deq_req_index}, 32'h0);
        #1;
        RST = 1'b0;
        $display("reset applied");
    endtask

    initial begin
        logic [3:0]       ev, ah;
        logic [1:0]       ai;
        logic [3:0][31:0] d;
        int               last;
        int               j;

        RST = 1'b1;
        enq_valid_vec = '0; enq_data_by_req = '0; ack_one_hot = '0; ack_index = '0;
        exp_dv = 1'b0; exp_dd = '0; exp_idx = '0;
        @(posedge CLK);
        #2;
        do_reset();

        // Enqueue 0xA5 on q2, then grant q2.
        step(4'b0100, lane(2, 32'hA5), 4'b0000, 2'd0);
        cmp("t2_req_vec", {28'd0, req_vec}, 32'h4);
        step(4'b0000, '0, 4'b0100, 2'd2);
        cmp("t2_deq_data", deq_data, 32'hA5);
        cmp("t2_deq_idx", {30'd0, deq_req_index}, 32'h2);
        cmp("t2_req_vec_empty", {28'd0, req_vec}, 32'h0);

        // Fill q0 with 1..4. A push while it is full is refused even in the cycle it is popped.
        for (int k = 1; k <= 4; k++) step(4'b0001, lane(0, k), 4'b0000, 2'd0);
        cmp("t3_full", {31'd0, enq_ready_vec[0]}, 32'h0);
        step(4'b0001, lane(0, 32'h5), 4'b0001, 2'd0);
        cmp("t3_first", deq_data, 32'h1);
        cmp("t3_ready_again", {31'd0, enq_ready_vec[0]}, 32'h1);
        for (int k = 2; k <= 4; k++) begin
            step(4'b0000, '0, 4'b0001, 2'd0);
            cmp("t3_drain", deq_data, k);
        end

        // q1 holds one entry; a push and a pop in the same cycle keep it at one entry.
        step(4'b0010, lane(1, 32'h11), 4'b0000, 2'd0);
        step(4'b0010, lane(1, 32'h22), 4'b0010, 2'd1);
        cmp("t4_head", deq_data, 32'h11);
        cmp("t4_req1", {31'd0, req_vec[1]}, 32'h1);
        step(4'b0000, '0, 4'b0010, 2'd1);
        cmp("t4_second", deq_data, 32'h22);

        // Spurious grants: an empty queue, and a one-hot bit that disagrees with the index.
        step(4'b0101, lane(0, 32'h77) | lane(2, 32'h99), 4'b0000, 2'd0);
        step(4'b0000, '0, 4'b1000, 2'd3);
        cmp("t5_empty_grant", {31'd0, deq_valid}, 32'h0);
        step(4'b0000, '0, 4'b0001, 2'd2);
        cmp("t5_mismatch", {31'd0, deq_valid}, 32'h0);
        cmp("t5_req_kept", {28'd0, req_vec}, 32'h5);
        step(4'b0000, '0, 4'b0001, 2'd0);
        step(4'b0000, '0, 4'b0100, 2'd2);

        // Two entries per queue, granted round robin by the bench.
        for (int k = 0; k < 2; k++) step(4'b1111, {32'h30+k, 32'h20+k, 32'h10+k, 32'h00+k}, 4'b0000, 2'd0);
        last = 3;
        for (int k = 0; k < 8; k++) begin
            j = (last + 1) % 4;
            while (mq[j].size() == 0) j = (j + 1) % 4;
            last = j;
            step(4'b0000, '0, 4'b0001 << j, 2'(j));
            cmp("t6_rr_idx", {30'd0, deq_req_index}, k % 4);
        end
        step(4'b0000, '0, 4'b0000, 2'd0);
        cmp("t6_idle_valid", {31'd0, deq_valid}, 32'h0);
        cmp("t6_idle_req", {28'd0, req_vec}, 32'h0);

        // Reset in mid-run discards all queued entries.
        step(4'b1111, {32'h3, 32'h2, 32'h1, 32'h0}, 4'b0000, 2'd0);
        do_reset();
        step(4'b0000, '0, 4'b0001, 2'd0);
        cmp("t6_after_rst", {31'd0, deq_valid}, 32'h0);

        // Randomized traffic. Grants are mostly consistent, with some spurious patterns mixed in.
        for (int n = 0; n < 600; n++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            ev = 4'($urandom) & 4'($urandom_range(0, 15));
            ai = 2'($urandom_range(0, 3));
            j  = $urandom_range(0, 9);
            if (j < 7)      ah = 4'b0001 << ai;
            else if (j < 9) ah = 4'($urandom);
            else            ah = 4'b0000;
            step(ev, d, ah, ai);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
